// File: rtl/dflop_state_reader.sv
// Sampled-register readout: captures d on strobe, counts samples, timestamps cycles,
// and streams a snapshot {A5, q, cnt, ts} as a byte frame over valid/ready.
module dflop_state_reader #(
    parameter int DW = 4,
    parameter int CW = 32,
    parameter int TW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d,
    input  logic          d_en,
    input  logic          rd_req,
    output logic          busy,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);

    localparam int NB = 2 + CW / 8 + TW / 8;
    localparam int FW = NB * 8;
    localparam int IW = $clog2(NB);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   q_q, q_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   ts_q, ts_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic [7:0]      q_byte;

    always_comb begin
        q_d     = d_en ? d : q_q;
        cnt_d   = cnt_q + CW'(d_en);
        ts_d    = ts_q + TW'(1);
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        last_d  = last_q;
        q_byte  = '0;
        q_byte[DW-1:0] = q_q;

        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    // Snapshot uses pre-edge values, so a coincident d_en is excluded.
                    frame_d = {8'hA5, q_byte, cnt_q, ts_q};
                    state_d = SEND;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    last_d  = (NB == 1);
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == IW'(NB - 1)) begin
                        state_d = IDLE;
                        frame_d = '0;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        frame_d = {frame_q[FW-9:0], 8'h00};
                        idx_d   = idx_q + IW'(1);
                        last_d  = (idx_q + IW'(1)) == IW'(NB - 1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            ts_q    <= '0;
            frame_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            ts_q    <= ts_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_data  = frame_q[FW-1 -: 8];

endmodule

// File: tb/tb_dflop_state_reader.sv
// Directed bench for dflop_state_reader: default instance plus a CW=8/TW=16 instance for counter wrap.
module tb_dflop_state_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] d = '0;
    logic       d_en = 1'b0;
    logic       rd_req = 1'b0;
    logic       out_ready = 1'b1;
    logic       busy, out_valid, out_last;
    logic [7:0] out_data;

    logic [3:0] d_w = '0;
    logic       d_en_w = 1'b0;
    logic       rd_req_w = 1'b0;
    logic       busy_w, out_valid_w, out_last_w;
    logic [7:0] out_data_w;

    int checks = 0;
    int failures = 0;
    int ts_m = 0;

    always #5 clk = ~clk;

    dflop_state_reader dut (
        .clk(clk), .rst(rst), .d(d), .d_en(d_en), .rd_req(rd_req),
        .busy(busy), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    dflop_state_reader #(.DW(4), .CW(8), .TW(16)) dut_w (
        .clk(clk), .rst(rst), .d(d_w), .d_en(d_en_w), .rd_req(rd_req_w),
        .busy(busy_w), .out_data(out_data_w), .out_valid(out_valid_w),
        .out_ready(1'b1), .out_last(out_last_w)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) ts_m++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        ts_m = 0;
    endtask

    function automatic logic [111:0] mk(input logic [7:0] q, input logic [31:0] c, input logic [63:0] t);
        return {8'hA5, q, c, t};
    endfunction

    // mode 0: ready high; 1: stall 3 cycles on byte 4 then toggle; 2: ready high, rd_req pulses mid-frame and on last byte
    task automatic recv(input logic [111:0] exp, input int mode);
        int   k = 0;
        int   stall = 0;
        int   busy_n = 0;
        logic tog = 1'b1;
        logic rdy;
        for (int cyc = 0; cyc < 300 && k < 14; cyc++) begin
            chk("valid", {63'b0, out_valid}, 64'd1);
            chk("busy", {63'b0, busy}, 64'd1);
            chk($sformatf("byte%0d", k), {56'b0, out_data}, {56'b0, exp[111-8*k -: 8]});
            chk("last", {63'b0, out_last}, {63'b0, (k == 13)});
            busy_n++;
            rdy = 1'b1;
            if (mode == 1) begin
                if (k == 4 && stall < 3) begin
                    rdy = 1'b0;
                    stall++;
                end else if (k >= 4) begin
                    rdy = tog;
                    tog = ~tog;
                end
            end
            out_ready = rdy;
            rd_req = (mode == 2) && (k == 5 || k == 13);
            step();
            if (rdy) k++;
        end
        rd_req = 1'b0;
        out_ready = 1'b1;
        chk("frame_len", 64'(k), 64'd14);
        if (mode == 0) chk("busy_cycles", 64'(busy_n), 64'd14);
        chk("idle_valid", {63'b0, out_valid}, 64'd0);
        chk("idle_busy", {63'b0, busy}, 64'd0);
        chk("idle_last", {63'b0, out_last}, 64'd0);
    endtask

    task automatic recv_w(input logic [39:0] exp);
        for (int k = 0; k < 5; k++) begin
            chk("w_valid", {63'b0, out_valid_w}, 64'd1);
            chk($sformatf("w_byte%0d", k), {56'b0, out_data_w}, {56'b0, exp[39-8*k -: 8]});
            chk("w_last", {63'b0, out_last_w}, {63'b0, (k == 4)});
            step();
        end
        chk("w_idle_valid", {63'b0, out_valid_w}, 64'd0);
        chk("w_idle_busy", {63'b0, busy_w}, 64'd0);
    endtask

    task automatic basic_setup();
        while (ts_m < 1) step();
        d = 4'd3; d_en = 1'b1; step();
        d = 4'd5; step();
        d = 4'd9; step();
        d_en = 1'b0;
        while (ts_m < 10) step();
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    initial begin
        logic [111:0] exp;
        logic [39:0]  exp_w;

        #3;
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_data", {56'b0, out_data}, 64'd0);
        chk("rst_last", {63'b0, out_last}, 64'd0);
        #9;
        rst = 1'b1;
        ts_m = 0;

        basic_setup();
        recv(112'hA5_09_00000003_000000000000000A, 0);

        step();
        do_reset();
        basic_setup();
        recv(112'hA5_09_00000003_000000000000000A, 1);

        exp = mk(8'h09, 32'd3, 64'(ts_m));
        d = 4'd7; d_en = 1'b1; rd_req = 1'b1;
        step();
        d_en = 1'b0; rd_req = 1'b0;
        recv(exp, 0);

        step();
        exp = mk(8'h07, 32'd4, 64'(ts_m));
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        recv(exp, 2);

        exp = mk(8'h07, 32'd4, 64'(ts_m));
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        recv(exp, 0);
        repeat (3) step();
        chk("no_extra_frame", {63'b0, out_valid}, 64'd0);

        do_reset();
        d_w = 4'hF; d_en_w = 1'b1;
        repeat (255) step();
        d_en_w = 1'b0;
        exp_w = {8'hA5, 8'h0F, 8'hFF, 16'(ts_m)};
        rd_req_w = 1'b1;
        step();
        rd_req_w = 1'b0;
        recv_w(exp_w);
        d_en_w = 1'b1;
        step();
        d_en_w = 1'b0;
        exp_w = {8'hA5, 8'h0F, 8'h00, 16'(ts_m)};
        rd_req_w = 1'b1;
        step();
        rd_req_w = 1'b0;
        recv_w(exp_w);

        d = 4'd6; d_en = 1'b1;
        step();
        d_en = 1'b0;
        exp = mk(8'h06, 32'd1, 64'(ts_m));
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        repeat (6) step();
        chk("pre_rst_byte6", {56'b0, out_data}, {56'b0, exp[111-48 -: 8]});
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", {63'b0, out_valid}, 64'd0);
        chk("async_busy", {63'b0, busy}, 64'd0);
        chk("async_data", {56'b0, out_data}, 64'd0);
        chk("async_last", {63'b0, out_last}, 64'd0);
        step();
        #2;
        rst = 1'b1;
        ts_m = 0;
        repeat (3) step();
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        recv(112'hA5_00_00000000_0000000000000003, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
